// File: rtl/custom_cells_unswap.sv
// Receive-side inverse of the registered a/b swap stage: re-aligns sel with the swapped
// lanes, recovers the original a/b pair and queues it in a small FIFO for a valid/ready sink.
module custom_cells_unswap #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           y_i,
  input  logic [WIDTH-1:0]           z_i,
  input  logic                       sel_i,
  input  logic                       in_valid_i,
  output logic [WIDTH-1:0]           a_o,
  output logic [WIDTH-1:0]           b_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  input  logic                       clr_err_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  typedef enum logic {WARMUP = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    warm_cnt_q, warm_cnt_d;
  logic [LATENCY-1:0] sel_dly_q, sel_dly_d;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [LW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             ovf_q, ovf_d;

  logic             sel_d;
  logic [WIDTH-1:0] rec_a, rec_b;
  logic             full, empty, push, pop, ovf_evt;

  // Handshake: a pair leaves the FIFO on any rising edge where valid_o & ready_i;
  // a_o/b_o never change while valid_o is high and ready_i is low.

  // FSM: WARMUP waits LATENCY cycles so the sel delay line holds real history.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      WARMUP: begin
        if (warm_cnt_q == CW'(LATENCY - 1)) state_d = RUN;
        else                                warm_cnt_d = warm_cnt_q + CW'(1);
      end
      RUN:     state_d = RUN;
      default: state_d = WARMUP;
    endcase
  end

  always_comb begin
    sel_dly_d[0] = sel_i;
    for (int i = 1; i < LATENCY; i++) sel_dly_d[i] = sel_dly_q[i-1];
  end

  assign sel_d = sel_dly_q[LATENCY-1];
  assign rec_a = sel_d ? z_i : y_i;
  assign rec_b = sel_d ? y_i : z_i;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = ~empty & ready_i;
  assign push    = (state_q == RUN) & in_valid_i & (~full | pop);
  assign ovf_evt = (state_q == RUN) & in_valid_i & full & ~pop;
  assign rd_next = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_next           : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_evt ? 1'b1 : (clr_err_i ? 1'b0 : ovf_q);
  end

  // Registered head: mirrors mem[rd_ptr] while non-empty, keeps the last popped pair otherwise.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (empty && push) begin
      a_d = rec_a;
      b_d = rec_b;
    end else if (pop) begin
      if (count_q > LW'(1)) begin
        a_d = mem_a[rd_next];
        b_d = mem_b[rd_next];
      end else if (push) begin
        a_d = rec_a;
        b_d = rec_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= WARMUP;
      warm_cnt_q <= '0;
      sel_dly_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      sel_dly_q  <= sel_dly_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= rec_a;
      mem_b[wr_ptr_q] <= rec_b;
    end
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign valid_o    = ~empty;
  assign level_o    = count_q;
  assign overflow_o = ovf_q;

endmodule
